// File: rtl/rv_issue_sched_if.sv
// Handshake bundle between the reservation-station queue, the issue scheduler and the
// execution pipe.
interface rv_issue_sched_if #(
  parameter int unsigned q_num_entries_g = 16,
  parameter int unsigned q_dat_width_g   = 7,
  parameter int unsigned q_idx_width_g   = 4
);
  logic                                     flush;
  logic                                     hold;
  logic [q_num_entries_g-1:0]               ent_rdy;
  logic [q_dat_width_g*q_num_entries_g-1:0] ent_dat;
  logic [q_num_entries_g-1:0]               ent_issued;
  logic                                     iss_v;
  logic [q_dat_width_g-1:0]                 iss_dat;
  logic [q_idx_width_g-1:0]                 iss_idx;
  logic                                     iss_take;
  logic                                     iss_stall;
  logic [15:0]                              iss_cnt;

  // Queue / execution-pipe side.
  modport master (
    output flush, hold, ent_rdy, ent_dat, iss_take,
    input  ent_issued, iss_v, iss_dat, iss_idx, iss_stall, iss_cnt
  );

  // Scheduler side.
  modport slave (
    input  flush, hold, ent_rdy, ent_dat, iss_take,
    output ent_issued, iss_v, iss_dat, iss_idx, iss_stall, iss_cnt
  );
endinterface

// File: rtl/rv_issue_sched.sv
// Oldest-first issue scheduler: picks the highest-index ready entry and loads it into a
// registered issue stage with valid/take handshake, stall detection and a load counter.
module rv_issue_sched #(
  parameter int unsigned q_num_entries_g = 16,
  parameter int unsigned q_dat_width_g   = 7,
  parameter int unsigned q_idx_width_g   = 4,
  parameter int unsigned q_stall_limit_g = 15
) (
  input  logic              clk,
  input  logic              rst,
  rv_issue_sched_if.slave   bus_io
);

  localparam logic [7:0] StallLimit = 8'(q_stall_limit_g);

  typedef enum logic [1:0] {StEmpty, StPresented, StStalled} state_e;

  state_e                   state_q;
  logic [q_dat_width_g-1:0] dat_q;
  logic [q_idx_width_g-1:0] idx_q;
  logic [15:0]              cnt_q;
  logic [7:0]               stall_cnt_q;

  logic [q_idx_width_g-1:0] sel;
  logic [q_dat_width_g-1:0] sel_dat;
  logic                     any_rdy;
  logic                     iss_v;
  logic                     load;

  // Later (higher) indices override earlier ones, so the oldest ready entry wins.
  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    for (int i = 0; i < int'(q_num_entries_g); i++) begin
      if (bus_io.ent_rdy[i]) begin
        sel     = q_idx_width_g'(i);
        any_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < int'(q_num_entries_g); i++) begin
      if (sel == q_idx_width_g'(i)) begin
        sel_dat = bus_io.ent_dat[i*q_dat_width_g +: q_dat_width_g];
      end
    end
  end

  assign iss_v = (state_q != StEmpty);
  assign load  = ~rst & ~bus_io.flush & ~bus_io.hold & any_rdy & (~iss_v | bus_io.iss_take);

  always_comb begin
    bus_io.ent_issued = '0;
    for (int i = 0; i < int'(q_num_entries_g); i++) begin
      bus_io.ent_issued[i] = load & (sel == q_idx_width_g'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      dat_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else if (bus_io.flush) begin
      // Payload and index are left as they were; only validity is killed.
      state_q     <= StEmpty;
      stall_cnt_q <= '0;
    end else if (load) begin
      state_q     <= StPresented;
      dat_q       <= sel_dat;
      idx_q       <= sel;
      cnt_q       <= cnt_q + 16'd1;
      stall_cnt_q <= '0;
    end else if (iss_v) begin
      if (bus_io.iss_take) begin
        state_q     <= StEmpty;
        stall_cnt_q <= '0;
      end else if (stall_cnt_q >= StallLimit - 8'd1) begin
        // Reaching (or sitting at) the limit saturates the counter.
        state_q     <= StStalled;
        stall_cnt_q <= StallLimit;
      end else begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
    end
  end

  assign bus_io.iss_v     = iss_v;
  assign bus_io.iss_dat   = dat_q;
  assign bus_io.iss_idx   = idx_q;
  assign bus_io.iss_cnt   = cnt_q;
  assign bus_io.iss_stall = (state_q == StStalled);

endmodule

// File: tb/tb_rv_issue_sched.sv
// Directed bench for rv_issue_sched: taken issues are checked by a scoreboard monitor,
// control/stall/reset behaviour by inline checks.
module tb_rv_issue_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_issue_sched_if #(.q_num_entries_g(16), .q_dat_width_g(7), .q_idx_width_g(4)) m ();
  rv_issue_sched_if #(.q_num_entries_g(12), .q_dat_width_g(7), .q_idx_width_g(4)) m12 ();

  rv_issue_sched #(
    .q_num_entries_g(16), .q_dat_width_g(7), .q_idx_width_g(4), .q_stall_limit_g(15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (m)
  );

  rv_issue_sched #(
    .q_num_entries_g(12), .q_dat_width_g(7), .q_idx_width_g(4), .q_stall_limit_g(15)
  ) dut12 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (m12)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [6:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] idx, input logic [6:0] dat);
    exp_t e;
    e.idx = idx;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted issue of the 16-entry instance is popped and compared.
  always @(negedge clk) begin
    if (!rst && !m.flush && m.iss_v && m.iss_take) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_take", {21'd0, m.iss_idx, m.iss_dat}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_idx", m.iss_idx, e.idx);
        chk("sb_dat", m.iss_dat, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Entry i payload is 7'h40 | i in both instances.
    for (int i = 0; i < 16; i++) m.ent_dat[i*7 +: 7] = 7'h40 | 7'(i);
    for (int i = 0; i < 12; i++) m12.ent_dat[i*7 +: 7] = 7'h40 | 7'(i);
    rst = 1'b1;
    m.flush = 1'b0;   m.hold = 1'b0;   m.iss_take = 1'b0;   m.ent_rdy = '1;
    m12.flush = 1'b0; m12.hold = 1'b0; m12.iss_take = 1'b0; m12.ent_rdy = '0;

    @(negedge clk);
    chk("issued_in_rst", m.ent_issued, 32'h0);
    step();
    step();
    rst = 1'b0;
    m.ent_rdy = '0;
    @(negedge clk);
    chk("rst_v", m.iss_v, 0);
    chk("rst_dat", m.iss_dat, 0);
    chk("rst_idx", m.iss_idx, 0);
    chk("rst_stall", m.iss_stall, 0);
    chk("rst_cnt", m.iss_cnt, 0);

    // Priority: entries 0,5,10,15 ready, oldest (15) wins.
    step();
    m.ent_rdy = 16'h8421;
    push(4'd15, 7'h4F);
    @(negedge clk);
    chk("prio_issued", m.ent_issued, 32'h8000);
    step();
    m.ent_rdy = 16'h0421;
    @(negedge clk);
    chk("prio_v", m.iss_v, 1);
    chk("prio_idx", m.iss_idx, 15);
    chk("prio_dat", m.iss_dat, 7'h4F);
    chk("prio_cnt", m.iss_cnt, 1);
    chk("prio_issued_idle", m.ent_issued, 32'h0);

    // Back-to-back with take held high.
    step();
    m.iss_take = 1'b1;
    push(4'd10, 7'h4A);
    @(negedge clk);
    chk("b2b_issued10", m.ent_issued, 32'h0400);
    chk("b2b_v0", m.iss_v, 1);
    step();
    m.ent_rdy = 16'h0021;
    push(4'd5, 7'h45);
    @(negedge clk);
    chk("b2b_issued5", m.ent_issued, 32'h0020);
    chk("b2b_v1", m.iss_v, 1);
    step();
    m.ent_rdy = 16'h0001;
    push(4'd0, 7'h40);
    @(negedge clk);
    chk("b2b_issued0", m.ent_issued, 32'h0001);
    chk("b2b_v2", m.iss_v, 1);
    step();
    m.ent_rdy = '0;
    @(negedge clk);
    chk("b2b_v3", m.iss_v, 1);
    chk("b2b_issued_none", m.ent_issued, 32'h0);
    step();
    m.iss_take = 1'b0;
    @(negedge clk);
    chk("b2b_v_end", m.iss_v, 0);
    chk("b2b_cnt", m.iss_cnt, 4);

    // Backpressure and stall on entry 3.
    step();
    m.ent_rdy = 16'h0008;
    push(4'd3, 7'h43);
    @(negedge clk);
    chk("stall_issued", m.ent_issued, 32'h0008);
    step();
    m.ent_rdy = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("stall_flag", m.iss_stall, (k == 15) ? 1 : 0);
      chk("stall_dat", m.iss_dat, 7'h43);
      chk("stall_issued_none", m.ent_issued, 32'h0);
    end
    m.iss_take = 1'b1;
    step();
    m.iss_take = 1'b0;
    @(negedge clk);
    chk("stall_take_v", m.iss_v, 0);
    chk("stall_take_flag", m.iss_stall, 0);
    chk("stall_cnt", m.iss_cnt, 5);

    // Hold blocks loads but never drops a valid issue.
    step();
    m.hold = 1'b1;
    m.ent_rdy = '1;
    @(negedge clk);
    chk("hold_issued_empty", m.ent_issued, 32'h0);
    step();
    @(negedge clk);
    chk("hold_v_empty", m.iss_v, 0);
    chk("hold_cnt", m.iss_cnt, 5);
    step();
    m.hold = 1'b0;
    push(4'd15, 7'h4F);
    @(negedge clk);
    chk("hold_load_issued", m.ent_issued, 32'h8000);
    step();
    m.ent_rdy = 16'h7FFF;
    m.hold = 1'b1;
    @(negedge clk);
    chk("hold_v_kept0", m.iss_v, 1);
    step();
    @(negedge clk);
    chk("hold_v_kept1", m.iss_v, 1);
    step();
    m.iss_take = 1'b1;
    @(negedge clk);
    chk("hold_take_issued", m.ent_issued, 32'h0);
    step();
    m.iss_take = 1'b0;
    @(negedge clk);
    chk("hold_take_v", m.iss_v, 0);
    chk("hold_take_cnt", m.iss_cnt, 6);

    // Flush while stalled with take asserted.
    step();
    m.hold = 1'b0;
    @(negedge clk);
    chk("flush_load_issued", m.ent_issued, 32'h4000);
    step();
    m.ent_rdy = 16'h3FFF;
    for (int k = 1; k <= 15; k++) step();
    @(negedge clk);
    chk("flush_pre_stall", m.iss_stall, 1);
    step();
    m.flush = 1'b1;
    m.iss_take = 1'b1;
    @(negedge clk);
    chk("flush_issued", m.ent_issued, 32'h0);
    step();
    m.flush = 1'b0;
    m.iss_take = 1'b0;
    m.ent_rdy = '0;
    @(negedge clk);
    chk("flush_v", m.iss_v, 0);
    chk("flush_stall", m.iss_stall, 0);
    chk("flush_idx_held", m.iss_idx, 14);
    chk("flush_dat_held", m.iss_dat, 7'h4E);
    chk("flush_cnt", m.iss_cnt, 7);

    // Reset mid-operation while stalled.
    step();
    m.ent_rdy = 16'h2000;
    @(negedge clk);
    chk("rst2_load_issued", m.ent_issued, 32'h2000);
    step();
    m.ent_rdy = '0;
    for (int k = 1; k <= 15; k++) step();
    @(negedge clk);
    chk("rst2_pre_stall", m.iss_stall, 1);
    chk("rst2_pre_v", m.iss_v, 1);
    chk("rst2_pre_cnt", m.iss_cnt, 8);
    step();
    rst = 1'b1;
    m.iss_take = 1'b1;
    m.ent_rdy = 16'h1FFF;
    @(negedge clk);
    chk("rst2_issued", m.ent_issued, 32'h0);
    step();
    rst = 1'b0;
    m.iss_take = 1'b0;
    m.ent_rdy = '0;
    @(negedge clk);
    chk("rst2_v", m.iss_v, 0);
    chk("rst2_stall", m.iss_stall, 0);
    chk("rst2_cnt", m.iss_cnt, 0);
    chk("rst2_dat", m.iss_dat, 0);
    chk("rst2_idx", m.iss_idx, 0);

    // 12-entry instance: entry 11 first, then entry 0.
    step();
    m12.ent_rdy = 12'h801;
    m12.iss_take = 1'b1;
    @(negedge clk);
    chk("q12_issued11", m12.ent_issued, 32'h800);
    step();
    m12.ent_rdy = 12'h001;
    @(negedge clk);
    chk("q12_idx11", m12.iss_idx, 11);
    chk("q12_dat11", m12.iss_dat, 7'h4B);
    chk("q12_issued0", m12.ent_issued, 32'h001);
    step();
    m12.ent_rdy = '0;
    @(negedge clk);
    chk("q12_idx0", m12.iss_idx, 0);
    chk("q12_dat0", m12.iss_dat, 7'h40);
    chk("q12_v", m12.iss_v, 1);
    chk("q12_cnt", m12.iss_cnt, 2);
    step();
    m12.iss_take = 1'b0;
    @(negedge clk);
    chk("q12_v_end", m12.iss_v, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
